tone_rom_sequencer: RTL and testbench

Sequences playback of a tone look-up ROM at the audio sample rate and presents each sample on a valid/ready stream toward the equalizer filter bank. It contains a sample-rate tick divider and a wrapping address counter, and it absorbs the ROM's one-cycle registered read latency. It also flags ticks lost to downstream back-pressure. It sits between a tone ROM (e.g. `rom_8000`) and the first filter stage.

---
 rtl/tone_seq_pkg.sv | 16 +
 rtl/tone_rom_sequencer_tick_gen.sv | 40 ++++
 rtl/tone_rom_sequencer.sv | 123 ++++++++++++
 tb/tb_tone_rom_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/tone_seq_pkg.sv
// Shared types and default constants for the tone ROM sequencer.
package tone_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FETCH = 2'd2,
        HOLD  = 2'd3
    } tone_state_e;

    // 50 MHz system clock divided down to an 8 kHz sample rate.
    localparam int TONE_TICK_DIV_8K  = 6250;
    // Entries in one period of the stored tone.
    localparam int TONE_TABLE_LEN_8K = 6;

endpackage

// File: rtl/tone_rom_sequencer_tick_gen.sv
// Sample-rate divider: free-running 0..TICK_DIV-1 counter that is
// held at zero whenever the enable is low.
module sample_tick_gen #(
    parameter int TICK_DIV = 6250
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear while disabled, otherwise wrap at the terminal value.
    always_comb begin
        cnt_d = '0;
        if (en) begin
            if (cnt_q == CW'(TICK_DIV - 1)) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == CW'(TICK_DIV - 1));

endmodule

// File: rtl/tone_rom_sequencer.sv
// Plays a tone look-up ROM at the sample rate and hands each sample to
// the filter bank over a valid/ready stream. The ROM (one-cycle registered
// read) lives in the parent; this block drives its address and captures
// its data one state later.
module tone_rom_sequencer
    import tone_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int TABLE_LEN  = TONE_TABLE_LEN_8K,
    parameter int TICK_DIV   = TONE_TICK_DIV_8K
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         stop,
    output logic [ADDR_WIDTH-1:0]        rom_addr,
    input  logic signed [DATA_WIDTH-1:0] rom_data,
    output logic signed [DATA_WIDTH-1:0] sample,
    output logic                         sample_valid,
    input  logic                         sample_ready,
    output logic                         running,
    output logic                         period_done,
    output logic                         overrun
);

    tone_state_e                  state_q;
    logic [ADDR_WIDTH-1:0]        addr_q;
    logic signed [DATA_WIDTH-1:0] sample_q;
    logic                         valid_q;
    logic                         running_q;
    logic                         period_done_q;
    logic                         overrun_q;

    logic tick;
    logic tick_en;

    // The divider is cleared by dropping its enable: in IDLE, and on the
    // cycle a start or stop is taken so a (re)start begins counting at 0.
    assign tick_en = running_q && !start && !stop;

    sample_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (tick_en),
        .tick (tick)
    );

    // Playback FSM with all stream and status outputs registered; stop has
    // priority over start, and start restarts from any state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            sample_q      <= '0;
            valid_q       <= 1'b0;
            running_q     <= 1'b0;
            period_done_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            period_done_q <= 1'b0;
            if (stop) begin
                state_q   <= IDLE;
                addr_q    <= '0;
                valid_q   <= 1'b0;
                running_q <= 1'b0;
            end else if (start) begin
                state_q   <= WAIT;
                addr_q    <= '0;
                valid_q   <= 1'b0;
                running_q <= 1'b1;
                overrun_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        addr_q <= '0;
                    end
                    WAIT: begin
                        if (tick) begin
                            state_q <= FETCH;
                        end
                    end
                    FETCH: begin
                        state_q  <= HOLD;
                        sample_q <= rom_data;
                        valid_q  <= 1'b1;
                        if (tick) begin
                            overrun_q <= 1'b1;
                        end
                    end
                    HOLD: begin
                        if (tick) begin
                            overrun_q <= 1'b1;
                        end
                        if (valid_q && sample_ready) begin
                            state_q <= WAIT;
                            valid_q <= 1'b0;
                            if (addr_q == ADDR_WIDTH'(TABLE_LEN - 1)) begin
                                addr_q        <= '0;
                                period_done_q <= 1'b1;
                            end else begin
                                addr_q <= addr_q + ADDR_WIDTH'(1);
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign rom_addr     = addr_q;
    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign running      = running_q;
    assign period_done  = period_done_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_tone_rom_sequencer.sv
// Directed bench for tone_rom_sequencer with a short divider and a
// six-entry tone ROM modelled locally with one-cycle registered read.
module tb_tone_rom_sequencer;

    localparam int DW    = 8;
    localparam int AW    = 10;
    localparam int TLEN  = 6;
    localparam int TDIV  = 8;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic                 stop;
    logic [AW-1:0]        romAddr;
    logic signed [DW-1:0] romData;
    logic signed [DW-1:0] sample;
    logic                 sampleValid;
    logic                 sampleReady;
    logic                 running;
    logic                 periodDone;
    logic                 overrun;

    int checkCount;
    int errorCount;
    int expSamples [TLEN];

    tone_rom_sequencer #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .TABLE_LEN  (TLEN),
        .TICK_DIV   (TDIV)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .rom_addr     (romAddr),
        .rom_data     (romData),
        .sample       (sample),
        .sample_valid (sampleValid),
        .sample_ready (sampleReady),
        .running      (running),
        .period_done  (periodDone),
        .overrun      (overrun)
    );

    // Free-running system clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tone ROM contents for one period.
    function automatic logic signed [DW-1:0] romLookup(input logic [AW-1:0] a);
        case (a)
            10'd0:   romLookup = 8'sd0;
            10'd1:   romLookup = 8'sd121;
            10'd2:   romLookup = 8'sd75;
            10'd3:   romLookup = -8'sd75;
            10'd4:   romLookup = -8'sd121;
            default: romLookup = 8'sd0;
        endcase
    endfunction

    // Registered ROM read, one cycle behind the address.
    always @(posedge clk) begin
        romData <= romLookup(romAddr);
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic p);
        start = s;
        stop  = p;
        nextCycle();
        start = 1'b0;
        stop  = 1'b0;
    endtask

    // Advance until sample_valid is seen high, reporting cycles taken.
    task automatic waitValid(input int budget, output int cycles);
        cycles = 0;
        while (cycles < budget) begin
            nextCycle();
            cycles++;
            if (sampleValid) break;
        end
        if (!sampleValid) begin
            checkOutput("valid_timeout", 0, 1);
        end
    endtask

    initial begin
        int n;
        checkCount  = 0;
        errorCount  = 0;
        expSamples  = '{0, 121, 75, -75, -121, 0};
        rst         = 1'b1;
        start       = 1'b0;
        stop        = 1'b0;
        sampleReady = 1'b1;

        #12;
        checkOutput("rst_addr",    int'(romAddr), 0);
        checkOutput("rst_sample",  int'(sample), 0);
        checkOutput("rst_valid",   int'(sampleValid), 0);
        checkOutput("rst_running", int'(running), 0);
        checkOutput("rst_pdone",   int'(periodDone), 0);
        checkOutput("rst_overrun", int'(overrun), 0);
        @(negedge clk);
        rst = 1'b0;
        nextCycle();

        $display("[TB] basic playback");
        applyStimulus(1'b1, 1'b0);
        checkOutput("start_running", int'(running), 1);
        checkOutput("start_valid",   int'(sampleValid), 0);
        // Tick in the cycle ending at start+TDIV, FETCH, then valid.
        waitValid(40, n);
        checkOutput("first_latency", n, TDIV + 1);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                waitValid(40, n);
                checkOutput("sample_spacing", n, TDIV - 1);
            end
            checkOutput("sample_value", int'($signed(sample)), expSamples[i % TLEN]);
            nextCycle();
            checkOutput("accept_valid_low", int'(sampleValid), 0);
            checkOutput("accept_addr", int'(romAddr), (i + 1) % TLEN);
            checkOutput("period_done", int'(periodDone), (i % TLEN == TLEN - 1) ? 1 : 0);
        end
        checkOutput("no_overrun", int'(overrun), 0);

        $display("[TB] back-pressure");
        applyStimulus(1'b1, 1'b0);
        waitValid(40, n);
        checkOutput("bp_first", int'($signed(sample)), 0);
        nextCycle();
        sampleReady = 1'b0;
        waitValid(40, n);
        for (int c = 0; c < 20; c++) begin
            checkOutput("bp_hold_sample", int'($signed(sample)), 121);
            checkOutput("bp_hold_valid", int'(sampleValid), 1);
            nextCycle();
        end
        checkOutput("bp_hold_addr", int'(romAddr), 1);
        checkOutput("bp_overrun", int'(overrun), 1);
        sampleReady = 1'b1;
        nextCycle();
        checkOutput("bp_accept_valid", int'(sampleValid), 0);
        checkOutput("bp_accept_addr", int'(romAddr), 2);
        waitValid(40, n);
        checkOutput("bp_no_skip", int'($signed(sample)), 75);
        checkOutput("bp_overrun_sticky", int'(overrun), 1);

        $display("[TB] stop and restart");
        applyStimulus(1'b0, 1'b1);
        checkOutput("stop_valid",   int'(sampleValid), 0);
        checkOutput("stop_running", int'(running), 0);
        checkOutput("stop_addr",    int'(romAddr), 0);
        checkOutput("stop_sample",  int'($signed(sample)), 75);
        checkOutput("stop_overrun", int'(overrun), 1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("startstop_running", int'(running), 0);
        repeat (12) nextCycle();
        checkOutput("startstop_valid", int'(sampleValid), 0);
        checkOutput("startstop_overrun", int'(overrun), 1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("restart_running", int'(running), 1);
        checkOutput("restart_overrun", int'(overrun), 0);
        waitValid(40, n);
        checkOutput("restart_latency", n, TDIV + 1);
        checkOutput("restart_sample", int'($signed(sample)), 0);
        nextCycle();
        waitValid(40, n);
        checkOutput("restart_second", int'($signed(sample)), 121);
        nextCycle();
        repeat (3) nextCycle();
        applyStimulus(1'b1, 1'b0);
        checkOutput("midrestart_addr", int'(romAddr), 0);
        checkOutput("midrestart_valid", int'(sampleValid), 0);
        waitValid(40, n);
        checkOutput("midrestart_latency", n, TDIV + 1);
        checkOutput("midrestart_sample", int'($signed(sample)), 0);

        $display("[TB] async reset in HOLD");
        nextCycle();
        waitValid(40, n);
        checkOutput("pre_reset_sample", int'($signed(sample)), 121);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_valid",   int'(sampleValid), 0);
        checkOutput("arst_sample",  int'(sample), 0);
        checkOutput("arst_running", int'(running), 0);
        checkOutput("arst_addr",    int'(romAddr), 0);
        checkOutput("arst_pdone",   int'(periodDone), 0);
        checkOutput("arst_overrun", int'(overrun), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) nextCycle();
        checkOutput("post_reset_valid",   int'(sampleValid), 0);
        checkOutput("post_reset_running", int'(running), 0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
